// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a small circular FIFO and are
// shifted out LSB-first at OSCRATE/BAUDRATE clocks per bit.
module uart_tx_fifo #(
    parameter int OSCRATE  = 12_000_000,
    parameter int BAUDRATE = 9600,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int DIV = OSCRATE / BAUDRATE;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          empty, full, push, pop, wrap;
    logic [7:0]    head;

    // The extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = wr_valid && !full;
    assign wrap  = (cnt_q == CW'(DIV - 1));
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ready   = !full;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign tx         = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (wrap) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The line level is registered from the next state so tx never glitches.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-timestamp model of the transmitter predicts
// tx, busy, wr_ready and fifo_count after every clock edge.
module tb_uart_tx_fifo;
    localparam int OSC   = 160;
    localparam int BAUD  = 10;
    localparam int DIV   = OSC / BAUD;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready, tx, busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(.OSCRATE(OSC), .BAUDRATE(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: waiting bytes, and the edge window [line_start, line_end) of the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    int cyc = 0;
    int line_start = 0;
    int line_end = 0;

    function automatic logic [5:0] model_out();
        logic etx;
        int   t;
        etx = 1'b1;
        if (cyc < line_end) begin
            t = (cyc - line_start) / DIV;
            if (t == 0)      etx = 1'b0;
            else if (t <= 8) etx = cur[t-1];
        end
        return {etx, (cyc < line_end) || (mq.size() != 0),
                mq.size() < DEPTH, 3'(mq.size())};
    endfunction

    function automatic logic model_idle();
        return (cyc >= line_end) && (mq.size() == 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        line_start = 0;
        line_end = 0;
    endtask

    // Applies one write request across one clock edge and advances the model.
    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        logic popping;
        wr_valid = v;
        wr_data  = d;
        @(posedge clk);
        cyc++;
        acc = v && (mq.size() < DEPTH) && rst_n;
        popping = (mq.size() != 0) && (cyc >= line_end) && rst_n;
        if (popping) begin
            cur = mq.pop_front();
            line_start = cyc;
            line_end = cyc + 10 * DIV;
        end
        if (acc) mq.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        logic acc;
        logic [5:0] obs, exp;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_single_byte();
        logic acc;
        logic [5:0] obs, exp;
        step(1'b1, 8'h55, acc);
        for (int i = 0; i < 10 * DIV + 20; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single_55 cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [5:0] obs, exp;
        step(1'b1, 8'hA3, acc);
        step(1'b1, 8'h0F, acc);
        for (int i = 0; i < 20 * DIV + 20; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_fill_full();
        logic acc;
        logic [5:0] obs, exp;
        int idx = 0;
        for (int i = 0; i < 80 * DIV && !(idx == 6 && model_idle()); i++) begin
            step(idx < 6, 8'(idx + 1), acc);
            if (acc) idx++;
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fill_full cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
        vectors++;
        if (!(idx == 6 && model_idle())) begin
            miscompares++;
            $display("FAIL fill_full_timeout bytes_sent got %0d want 6", idx);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fill_tail cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_random_traffic();
        logic acc;
        logic [5:0] obs, exp;
        logic v;
        for (int i = 0; i < 3000; i++) begin
            // Heavy load first so full-FIFO pops collide with writes, then sparse writes.
            v = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 200) == 0);
            step(v, 8'($urandom), acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
        for (int i = 0; i < 60 * DIV && !model_idle(); i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random_drain cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic acc;
        logic [5:0] obs, exp;
        step(1'b1, 8'hFF, acc);
        step(1'b1, 8'h5A, acc);
        step(1'b1, 8'hC3, acc);
        for (int i = 0; i < 20 * DIV && cyc < line_start + 3 * DIV + 5; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pre_reset cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
        // Reset lands between edges; outputs must respond before the next edge.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        obs = {tx, busy, wr_ready, fifo_count};
        exp = model_out();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL async_reset cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
        end
        step(1'b0, 8'h00, acc);
        step(1'b0, 8'h00, acc);
        rst_n = 1'b1;
        for (int i = 0; i < 12 * DIV; i++) begin
            step(1'b0, 8'h00, acc);
            obs = {tx, busy, wr_ready, fifo_count};
            exp = model_out();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d {tx,busy,rdy,cnt} got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fill_full();
        test_random_traffic();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
